// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned WordW    = 32;
   localparam int unsigned NumLanes = 4;
   localparam int unsigned LaneW    = WordW / NumLanes;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   // Wait counter width; 4 bits covers the full 1..15 latency range.
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency <= 15) ? 4 : $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AddrW = $clog2(DEPTH_WORDS)
) (
   input  logic                clk_i,
   input  logic                en_i,
   input  logic                we_i,
   input  logic [NumLanes-1:0] be_i,
   input  logic [AddrW-1:0]    addr_i,
   input  logic [WordW-1:0]    wdata_i,
   output logic [WordW-1:0]    rdata_o
);

   logic [WordW-1:0] mem_q [DEPTH_WORDS];
   logic [WordW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < NumLanes; i++) begin
               if (be_i[i]) begin
                  mem_q[addr_i][i*LaneW +: LaneW] <= wdata_i[i*LaneW +: LaneW];
               end
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: valid/ready request in, fixed-latency response out, one
// transaction outstanding at a time.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
   localparam int unsigned CntW  = cnt_width(LATENCY);
   // 33-bit bounds so a window ending exactly at 2^32 does not wrap.
   localparam logic [32:0] LoAddr  = {1'b0, BASE_ADDR};
   localparam logic [32:0] HiAddr  = LoAddr + 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            rd_q, rd_d;
   logic            accept;
   logic            addr_err;
   logic [31:0]     offset;
   logic [WordW-1:0] arr_rdata;
   logic            unused_offset;

   assign offset   = req_addr - BASE_ADDR;
   assign addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} < LoAddr)
                     || ({1'b0, req_addr} >= HiAddr);
   assign unused_offset = ^{offset[31:AddrW+2], offset[1:0]};

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign accept    = req_valid && req_ready;

   // Array read data is held until the next access, which cannot happen before IDLE.
   assign rsp_rdata = (rsp_valid && rd_q) ? arr_rdata : '0;
   assign rsp_err   = rsp_valid && err_q;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk_i  (clk),
      .en_i   (accept && !addr_err && !reset),
      .we_i   (req_we),
      .be_i   (req_be),
      .addr_i (offset[AddrW+1:2]),
      .wdata_i(req_wdata),
      .rdata_o(arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rd_d    = rd_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               err_d = addr_err;
               rd_d  = !req_we && !addr_err;
               if (LATENCY == 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               err_d   = 1'b0;
               rd_d    = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: five instances with different latencies and base addresses,
// a vector table, hand-written back-pressure/reset sequences and a randomised model run.
module tb_dmem_responder;

   localparam int NI = 5;
   localparam int unsigned LAT [NI] = '{1, 3, 4, 2, 1};
   localparam logic [31:0] BASES [NI] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF00};
   localparam int unsigned DW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [NI];
   logic        rv    [NI];
   logic        rdy   [NI];
   logic        we    [NI];
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic [3:0]  be    [NI];
   logic        rspv  [NI];
   logic        rspr  [NI];
   logic [31:0] rdata [NI];
   logic        err   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS(DW),
         .BASE_ADDR  (BASES[g]),
         .LATENCY    (LAT[g])
      ) u_dut (
         .clk      (clk),
         .reset    (rst[g]),
         .req_valid(rv[g]),
         .req_ready(rdy[g]),
         .req_we   (we[g]),
         .req_addr (addr[g]),
         .req_wdata(wdata[g]),
         .req_be   (be[g]),
         .rsp_valid(rspv[g]),
         .rsp_ready(rspr[g]),
         .rsp_rdata(rdata[g]),
         .rsp_err  (err[g])
      );
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      int          d;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      int          stall;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        tbl [19];
   logic [31:0] mdl [DW];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] r, input logic e);
      exp_t x;
      x.rdata = r;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   task automatic pop_exp(output exp_t x);
      chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) x = exp_q.pop_front();
      else begin
         x.rdata = 'x;
         x.err   = 1'bx;
      end
   endtask

   task automatic drive(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b);
      we[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      be[d]    = b;
      rv[d]    = 1'b1;
   endtask

   // Called at a negedge with the request driven; returns just after the accept edge.
   task automatic wait_accept(input int d);
      int n = 0;
      while (!rdy[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", rdy[d], 1);
      @(posedge clk);
      #1 rv[d] = 1'b0;
   endtask

   // Called just after the accept edge; checks latency, hold under stall and completion.
   task automatic wait_rsp(input int d, input int stall);
      int   n = 0;
      exp_t x;
      do begin
         @(negedge clk);
         n++;
         if (!rspv[d]) chk("busy_ready", rdy[d], 0);
      end while (!rspv[d] && n < 40);
      chk("rsp_latency", n, LAT[d]);
      pop_exp(x);
      rspr[d] = 1'b0;
      for (int i = 0; i < stall; i++) begin
         chk("hold_rdata", rdata[d], x.rdata);
         chk("hold_err", err[d], x.err);
         @(negedge clk);
         chk("hold_valid", rspv[d], 1);
         chk("hold_ready", rdy[d], 0);
      end
      chk("rdata", rdata[d], x.rdata);
      chk("err", err[d], x.err);
      rspr[d] = 1'b1;
      @(negedge clk);
      rspr[d] = 1'b0;
      chk("post_valid", rspv[d], 0);
      chk("post_rdata", rdata[d], 0);
      chk("post_err", err[d], 0);
      chk("post_ready", rdy[d], 1);
   endtask

   task automatic txn(input vec_t v);
      drive(v.d, v.we, v.a, v.wd, v.be);
      push_exp(v.er, v.ee);
      wait_accept(v.d);
      wait_rsp(v.d, v.stall);
   endtask

   function automatic logic model_err(input logic [31:0] base, input logic [31:0] a);
      logic [32:0] lo, hi;
      lo = {1'b0, base};
      hi = lo + 33'(DW * 4);
      return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 500000", $time);
      $fatal(1);
   end

   initial begin
      vec_t        v;
      exp_t        x;
      int          n;
      int unsigned k;
      logic [31:0] a, wd;
      logic [3:0]  b;
      logic        w, e;
      int          idx;

      tbl[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
      tbl[1]  = '{0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0};
      tbl[3]  = '{0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 1'b0};
      tbl[4]  = '{0, 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0};
      tbl[5]  = '{0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 32'h0, 1'b1};
      tbl[6]  = '{0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1'b1};
      tbl[7]  = '{0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1};
      tbl[8]  = '{0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 1'b0};
      tbl[9]  = '{0, 1'b1, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0};
      tbl[10] = '{0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0};
      tbl[11] = '{0, 1'b1, 32'hFC, 32'h12345678, 4'hF, 0, 32'h0, 1'b0};
      tbl[12] = '{0, 1'b0, 32'hFC, 32'h0, 4'h0, 0, 32'h12345678, 1'b0};
      tbl[13] = '{4, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0};
      tbl[14] = '{4, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0};
      tbl[15] = '{4, 1'b0, 32'hFFFFFEFC, 32'h0, 4'h0, 0, 32'h0, 1'b1};
      tbl[16] = '{4, 1'b0, 32'h00000000, 32'h0, 4'h0, 0, 32'h0, 1'b1};
      tbl[17] = '{4, 1'b1, 32'hFFFFFF00, 32'h0BADCAFE, 4'hF, 0, 32'h0, 1'b0};
      tbl[18] = '{4, 1'b0, 32'hFFFFFF00, 32'h0, 4'h0, 0, 32'h0BADCAFE, 1'b0};

      for (int d = 0; d < NI; d++) begin
         rst[d] = 1'b1; rv[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
         wdata[d] = '0; be[d] = '0; rspr[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < NI; d++) rst[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NI; d++) begin
         chk("reset_ready", rdy[d], 1);
         chk("reset_valid", rspv[d], 0);
         chk("reset_rdata", rdata[d], 0);
         chk("reset_err", err[d], 0);
      end

      // Vector table: basic read/write, byte lanes, errors, window edges.
      for (int i = 0; i < 19; i++) txn(tbl[i]);

      // LATENCY=3 with back-pressure and req_valid held high throughout.
      v = '{1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, 0, 32'h0, 1'b0};
      txn(v);
      drive(1, 1'b0, 32'h40, 32'h0, 4'h0);
      push_exp(32'h5A5A1234, 1'b0);
      chk("t4_ready_pre", rdy[1], 1);
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!rspv[1]) chk("t4_busy", rdy[1], 0);
      end while (!rspv[1] && n < 40);
      chk("t4_latency", n, 3);
      pop_exp(x);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_rdata", rdata[1], x.rdata);
         chk("t4_hold_ready", rdy[1], 0);
         @(negedge clk);
         chk("t4_hold_valid", rspv[1], 1);
      end
      chk("t4_rdata", rdata[1], x.rdata);
      chk("t4_err", err[1], x.err);
      rspr[1] = 1'b1;
      @(negedge clk);
      rspr[1] = 1'b0;
      chk("t4_post_valid", rspv[1], 0);
      chk("t4_post_ready", rdy[1], 1);
      push_exp(32'h5A5A1234, 1'b0);
      @(posedge clk);
      #1 rv[1] = 1'b0;
      wait_rsp(1, 0);

      // LATENCY=4: reset during WAIT discards the read, contents survive.
      v = '{2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0};
      txn(v);
      drive(2, 1'b0, 32'h30, 32'h0, 4'h0);
      @(posedge clk);
      #1 rv[2] = 1'b0;
      @(negedge clk);
      chk("t5_wait_valid", rspv[2], 0);
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      chk("t5_rst_ready", rdy[2], 1);
      chk("t5_rst_valid", rspv[2], 0);
      chk("t5_rst_rdata", rdata[2], 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t5_no_valid", rspv[2], 0);
      end
      v = '{2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0};
      txn(v);

      // LATENCY=2, rsp_ready tied high: fill, then random traffic against a model.
      rspr[3] = 1'b1;
      for (int i = 0; i < 64 + 200; i++) begin
         if (i < 64) begin
            w = 1'b1; a = 32'(i * 4); wd = $urandom; b = 4'hF;
         end else begin
            k  = $urandom_range(0, 9);
            w  = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            b  = 4'($urandom);
            if (k < 6)       a = 32'($urandom_range(0, 63) * 4);
            else if (k == 6) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (k == 7) a = 32'h100 + 32'($urandom_range(0, 255) * 4);
            else if (k == 8) a = 32'hFFFF_FFFC;
            else             a = 32'hFC;
         end
         e = model_err(BASES[3], a);
         idx = int'((a - BASES[3]) >> 2) % DW;
         if (e) push_exp(32'h0, 1'b1);
         else if (w) begin
            for (int l = 0; l < 4; l++) if (b[l]) mdl[idx][l*8 +: 8] = wd[l*8 +: 8];
            push_exp(32'h0, 1'b0);
         end else push_exp(mdl[idx], 1'b0);
         drive(3, w, a, wd, b);
         chk("t6_ready", rdy[3], 1);
         @(posedge clk);
         #1 rv[3] = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!rspv[3] && n < 20);
         chk("t6_latency", n, 2);
         chk("t6_busy", rdy[3], 0);
         pop_exp(x);
         chk("t6_rdata", rdata[3], x.rdata);
         chk("t6_err", err[3], x.err);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
